// File: rtl/cdb_pkg.sv
// Shared common-data-bus definitions: default widths, requester slot indices,
// the broadcast record used by ID and EXE, and the statistics counter step.
package cdb_pkg;

    localparam int CDB_NUM_REQ = 3;
    localparam int CDB_MAP_W   = 6;
    localparam int CDB_REG_W   = 5;
    localparam int CDB_DATA_W  = 32;

    localparam int CDB_REQ_EXE = 0;
    localparam int CDB_REQ_MEM = 1;
    localparam int CDB_REQ_BR  = 2;

    typedef struct packed {
        logic                  flag;
        logic [CDB_MAP_W-1:0]  map;
        logic [CDB_REG_W-1:0]  reg_idx;
        logic [CDB_DATA_W-1:0] val;
    } cdb_bcast_t;

    function automatic logic [31:0] cdb_sat_inc(input logic [31:0] cnt);
        return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_checker.sv
// Protocol and grant-shape assertions for cdb_arbiter; instantiated alongside
// the arbiter in simulation.
module cdb_arbiter_checker #(
    parameter int NUM_REQ = 3,
    parameter int MAP_W   = 6,
    parameter int REG_W   = 5,
    parameter int DATA_W  = 32
) (
    input logic                      CLK,
    input logic                      RESET,
    input logic                      flush,
    input logic [NUM_REQ-1:0]        req_valid,
    input logic [NUM_REQ*MAP_W-1:0]  req_map,
    input logic [NUM_REQ*REG_W-1:0]  req_reg,
    input logic [NUM_REQ*DATA_W-1:0] req_val,
    input logic [NUM_REQ-1:0]        req_ready
);

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_hold
        // A pending request must stay up with a stable payload until accepted or flushed
        a_hold: assert property (@(posedge CLK) disable iff (RESET)
            (req_valid[i] && !req_ready[i] && !flush) |=>
                (flush || (req_valid[i]
                           && $stable(req_map[i*MAP_W +: MAP_W])
                           && $stable(req_reg[i*REG_W +: REG_W])
                           && $stable(req_val[i*DATA_W +: DATA_W]))));
    end

    a_onehot: assert property (@(posedge CLK) $onehot0(req_ready));
    a_subset: assert property (@(posedge CLK) (req_ready & ~req_valid) == {NUM_REQ{1'b0}});

endmodule

// File: rtl/cdb_arbiter_rr.sv
// Combinational round-robin picker: first valid request at or after ptr,
// wrapping modulo NUM_REQ; mask suppresses every grant.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    input  logic               mask,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx
);

    logic [PTR_W:0]   sum_s;
    logic [PTR_W-1:0] pos_s;
    logic             hit_s;
    logic             found_s;

    // Scan priority order from ptr; ptr + k never exceeds 2*NUM_REQ-2, so one subtraction wraps it
    always_comb begin
        grant     = {NUM_REQ{1'b0}};
        grant_idx = {PTR_W{1'b0}};
        found_s   = 1'b0;
        sum_s     = {(PTR_W+1){1'b0}};
        pos_s     = {PTR_W{1'b0}};
        hit_s     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum_s        = {1'b0, ptr} + (PTR_W+1)'(k);
            sum_s        = (sum_s >= (PTR_W+1)'(NUM_REQ)) ? sum_s - (PTR_W+1)'(NUM_REQ) : sum_s;
            pos_s        = sum_s[PTR_W-1:0];
            hit_s        = !mask && !found_s && req[pos_s];
            grant[pos_s] = grant[pos_s] | hit_s;
            grant_idx    = hit_s ? pos_s : grant_idx;
            found_s      = found_s | hit_s;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter with a registered broadcast bus.
// Define CDB_STATS_EN to add the saturating conflict_count output.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_REQ = CDB_NUM_REQ,
    parameter int MAP_W   = CDB_MAP_W,
    parameter int REG_W   = CDB_REG_W,
    parameter int DATA_W  = CDB_DATA_W
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*MAP_W-1:0]  req_map,
    input  logic [NUM_REQ*REG_W-1:0]  req_reg,
    input  logic [NUM_REQ*DATA_W-1:0] req_val,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      broadcast_flag,
    output logic [MAP_W-1:0]          broadcast_map,
    output logic [REG_W-1:0]          broadcast_reg,
    output logic [DATA_W-1:0]         broadcast_val
`ifdef CDB_STATS_EN
    ,
    output logic [31:0]               conflict_count
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   rr_ptr_r;
    logic [NUM_REQ-1:0] grant_s;
    logic [PTR_W-1:0]   grant_idx_s;
    logic [PTR_W-1:0]   next_ptr_s;
    logic               accept_s;
    logic [MAP_W-1:0]   sel_map_s;
    logic [REG_W-1:0]   sel_reg_s;
    logic [DATA_W-1:0]  sel_val_s;

    // Reset is folded into the mask so no requester sees ready while it is held
    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr_r),
        .mask      (flush | RESET),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    assign req_ready  = grant_s;
    assign accept_s   = |grant_s;
    assign next_ptr_s = (grant_idx_s == PTR_W'(NUM_REQ - 1)) ? {PTR_W{1'b0}}
                                                             : grant_idx_s + PTR_W'(1);

    // One-hot AND-OR mux of the granted payload
    always_comb begin
        sel_map_s = {MAP_W{1'b0}};
        sel_reg_s = {REG_W{1'b0}};
        sel_val_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_map_s = sel_map_s | ({MAP_W{grant_s[i]}}  & req_map[i*MAP_W +: MAP_W]);
            sel_reg_s = sel_reg_s | ({REG_W{grant_s[i]}}  & req_reg[i*REG_W +: REG_W]);
            sel_val_s = sel_val_s | ({DATA_W{grant_s[i]}} & req_val[i*DATA_W +: DATA_W]);
        end
    end

    // Broadcast registers and priority pointer; payload holds when nothing is accepted
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rr_ptr_r       <= {PTR_W{1'b0}};
            broadcast_flag <= 1'b0;
            broadcast_map  <= {MAP_W{1'b0}};
            broadcast_reg  <= {REG_W{1'b0}};
            broadcast_val  <= {DATA_W{1'b0}};
        end else begin
            broadcast_flag <= accept_s;
            if (accept_s) begin
                rr_ptr_r      <= next_ptr_s;
                broadcast_map <= sel_map_s;
                broadcast_reg <= sel_reg_s;
                broadcast_val <= sel_val_s;
            end
        end
    end

`ifdef CDB_STATS_EN
    logic [31:0] conflict_count_r;
    logic        multi_req_s;

    // Two or more bits set exactly when clearing the lowest set bit leaves something
    assign multi_req_s = (req_valid & (req_valid - NUM_REQ'(1))) != {NUM_REQ{1'b0}};

    // Saturating count of contended, non-flushed cycles
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            conflict_count_r <= 32'd0;
        end else if (!flush && multi_req_s) begin
            conflict_count_r <= cdb_sat_inc(conflict_count_r);
        end
    end

    assign conflict_count = conflict_count_r;
`endif

endmodule
